// File: rtl/regfile_ctrl_pkg.sv
// Shared types and default widths for the register-file write-port controller.
//   ST_CLEAR / ST_ARB : controller states
//   RF_AW, RF_DW      : address / data widths of the register file write port
//   RF_DEPTH          : number of entries walked by a hardware clear
package regfile_ctrl_pkg;

    localparam int unsigned RF_AW    = 5;
    localparam int unsigned RF_DW    = 32;
    localparam int unsigned RF_DEPTH = 4;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       in  : per-requester request vector
//   ptr       in  : index of the highest-priority requester this cycle
//   enable    in  : when low, no grant is issued
//   grant     out : one-hot grant (all zero when nothing is granted)
//   grant_idx out : encoded index of the granted requester
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx
);

    logic          found;
    logic [PW-1:0] idx;

    // Scan upward from ptr with wrap; the first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PW'((32'(ptr) + k) % NREQ);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among NREQ requesters (round robin,
// valid/ready) and sequences a zero-fill clear after reset and on demand.
//   clk, reset           : clock, asynchronous active-low reset
//   req_valid/addr/data  : packed per-requester write requests
//   req_ready            : one-hot grant (combinational)
//   clear_start          : pulse requesting a full clear (ignored while clearing)
//   busy                 : high while clearing
//   regWrite/address3/writeData : registered register-file write port
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned DEPTH = RF_DEPTH,
    parameter int unsigned AW    = RF_AW,
    parameter int unsigned DW    = RF_DW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  req_ready,
    input  logic             clear_start,
    output logic             busy,
    output logic             regWrite,
    output logic [AW-1:0]    address3,
    output logic [DW-1:0]    writeData
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          busy_q, busy_d;

    logic            arb_en_c;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;

    // A clear request pre-empts any grant in the same cycle.
    assign arb_en_c = (state_q == ST_ARB) && !clear_start;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_q),
        .enable    (arb_en_c),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Next-state, clear sequencing and write-port selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_CLEAR: begin
                we_d   = 1'b1;
                addr_d = AW'(cnt_q);
                data_d = '0;
                if (cnt_q == CW'(DEPTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_ARB;
                end else begin
                    cnt_d = CW'(cnt_q + 1'b1);
                end
            end
            ST_ARB: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (|grant) begin
                    we_d   = 1'b1;
                    addr_d = req_addr[32'(grant_idx)*AW +: AW];
                    data_d = req_data[32'(grant_idx)*DW +: DW];
                    ptr_d  = (grant_idx == PW'(NREQ - 1)) ? '0 : PW'(grant_idx + 1'b1);
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // State and write-port registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign req_ready = grant;
    assign busy      = busy_q;
    assign regWrite  = we_q;
    assign address3  = addr_q;
    assign writeData = data_q;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 4-entry, 32-bit register file among several requesters using round-robin arbitration with a valid/ready handshake. It also sequences a hardware clear that walks every entry and writes zero, after reset and on demand. It sits between the requesting datapath units and the register file's `regWrite`/`address3`/`writeData` port. The register file's read ports are untouched.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `DEPTH`, 4: number of register entries to clear.
- `AW`, 5: address width.
- `DW`, 32: data width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester write request.
- `req_addr`  in  NREQ*AW  packed addresses; requester i is at [i*AW +: AW].
- `req_data`  in  NREQ*DW  packed data; requester i is at [i*DW +: DW].
- `req_ready`  out  NREQ  one-hot grant. A transfer happens when valid and ready are both high.
- `clear_start`  in  1  one-cycle pulse that requests a full clear.
- `busy`  out  1  high while clearing.
- `regWrite`  out  1  write enable to the register file.
- `address3`  out  AW  write address.
- `writeData`  out  DW  write data.

## Operation
- There are two states: CLEAR and ARB.
- **Reset.** While `reset` is low: state=CLEAR, clear counter=0, rr pointer=0, `regWrite`=0, `address3`=0, `writeData`=0, `busy`=1, `req_ready`=0.
- **CLEAR.** Each cycle emits one write of 0 to address=counter, then increments the counter.
  - After the write to DEPTH-1 is emitted, the counter returns to 0 and the state goes to ARB.
  - `req_ready` stays 0 throughout CLEAR.
- **ARB.** `req_ready` is combinational:
  - It grants the first valid requester found scanning from the rr pointer upward, wrapping from NREQ-1 to 0.
  - At most one bit is high. All bits are 0 if no requester is valid.
  - The granted address/data are registered onto the write port.
  - The rr pointer then moves to grantee+1 (mod NREQ).
  - If no grant occurs, the pointer holds.
- **clear_start in ARB.** `clear_start`=1 enters CLEAR on the next edge. No grant is issued in that cycle: `req_ready` is forced to 0.
- **clear_start in CLEAR.** The pulse is ignored; the clear is not restarted.
- **Requesters.** A requester must hold valid/addr/data stable until it sees ready.
- **Address range.** Addresses are passed through unchecked. Range checking is the requester's job.

## Timing
- **Write latency.** Handshake in cycle N gives `regWrite`=1 with the granted addr/data in cycle N+1, so the register file captures at edge N+2.
- **`regWrite` value.** `regWrite` is registered and is 0 in any cycle following a cycle with no write.
- **Throughput.** One write per cycle; back-to-back grants are allowed.
- **Fairness.** With all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. Each requester is served at least once every NREQ cycles.
- **Clear duration.** A clear takes exactly DEPTH cycles of `regWrite`=1. `busy` drops in the cycle the state becomes ARB, so the first grant is possible in that same cycle.
- **Reset release.** The clear starts on the first edge after release, with the address-0 write visible in the cycle after that edge.
- **Reset mid-operation.** An asynchronous assert takes effect immediately. The in-flight write is dropped (`regWrite`=0) and the clear restarts from address 0 after release.
- **Registered outputs.** All outputs except `req_ready` are registers.

## Structure
- A shared package `regfile_ctrl_pkg` holds:
  - the state enum (`ST_CLEAR`, `ST_ARB`);
  - the default widths (`RF_AW`=5, `RF_DW`=32, `RF_DEPTH`=4).
- One sub-module, `rr_arbiter`:
  - parameter NREQ;
  - inputs: `req` vector, `ptr`, `enable`;
  - outputs: one-hot `grant` and the encoded `grant_idx`;
  - purely combinational.
- The pointer register, the clear FSM and the write-port registers live in the top module.

## Test plan
- **Reset clear.** Release `reset` with no requests -> four cycles of writes: addr 0..3, data 0. `busy` falls after the fourth, and `req_ready` stays 0 until then.
- **Single requester.** In ARB, requester 1 presents addr 2, data 32'hDEADBEEF for one cycle -> `req_ready`=2'b10 that cycle, then `regWrite`=1, `address3`=2, `writeData`=32'hDEADBEEF the next cycle.
- **Round robin.** Both requesters continuously valid (r0: addr 0, 32'hA; r1: addr 1, 32'hB) starting with pointer=0 -> grants alternate 01,10,01,10, and the write port alternates (0,A),(1,B).
- **clear_start collisions.**
  - `clear_start` in the same cycle as a valid request -> `req_ready`=0, then 4 clear writes (addr 0..3), then the request is granted.
  - A second `clear_start` during the clear -> still exactly 4 writes.
- **Reset mid-clear.** Assert `reset` after the address-1 clear write and release 2 cycles later -> `regWrite` drops to 0 immediately; the clear restarts at address 0 and completes 0..3.
- **Idle gaps.** No valid requests for 5 cycles between grants -> `regWrite`=0 in each of those cycles, and the pointer is unchanged (the next grant follows round-robin from the last grantee+1).
